// File: rtl/mvb_rr_merge.sv
// rtl/mvb_rr_merge.sv - round-robin merge of MUX_WIDTH MVB streams into one tagged MVB stream
//
// Whole words are granted to one RX port at a time. Each TX item is tagged
// with the index of the port it came from. The tag lets a demux with the same
// port count route the item back to that port.
//
// Optional feature macro: MVB_MERGE_PRIO_EN
//   When defined, port 0 has strict priority over the other ports.
//   Ports 1..MUX_WIDTH-1 still round-robin among themselves.
//
// Ports:
//   CLK, RESET_N  clock (rising edge) and asynchronous active-low reset
//   RX_DATA       MUX_WIDTH input words; port p is slice p
//   RX_VLD        per-item valid per port
//   RX_SRC_RDY    per-port word present
//   RX_DST_RDY    per-port accept; one-hot or zero
//   TX_DATA       merged word
//   TX_SEL        source port index per item
//   TX_VLD        per-item valid of the merged word
//   TX_SRC_RDY    merged word present
//   TX_DST_RDY    downstream accept

module mvb_rr_merge #(
    parameter int MVB_ITEMS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MUX_WIDTH  = 4,
    localparam int SEL_WIDTH = $clog2(MUX_WIDTH)
) (
    input  logic                                     CLK,
    input  logic                                     RESET_N,
    input  logic [MUX_WIDTH*MVB_ITEMS*DATA_WIDTH-1:0] RX_DATA,
    input  logic [MUX_WIDTH*MVB_ITEMS-1:0]           RX_VLD,
    input  logic [MUX_WIDTH-1:0]                     RX_SRC_RDY,
    output logic [MUX_WIDTH-1:0]                     RX_DST_RDY,
    output logic [MVB_ITEMS*DATA_WIDTH-1:0]          TX_DATA,
    output logic [MVB_ITEMS*SEL_WIDTH-1:0]           TX_SEL,
    output logic [MVB_ITEMS-1:0]                     TX_VLD,
    output logic                                     TX_SRC_RDY,
    input  logic                                     TX_DST_RDY
);

    localparam int WORD_W = MVB_ITEMS * DATA_WIDTH;

`ifdef MVB_MERGE_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [SEL_WIDTH-1:0]           ptr_q, ptr_d;
    logic                           tx_src_rdy_q, tx_src_rdy_d;
    logic [WORD_W-1:0]              tx_data_q, tx_data_d;
    logic [MVB_ITEMS*SEL_WIDTH-1:0] tx_sel_q, tx_sel_d;
    logic [MVB_ITEMS-1:0]           tx_vld_q, tx_vld_d;

    logic                           free;
    logic                           gnt_vld;
    logic [SEL_WIDTH-1:0]           gnt_idx;
    logic [SEL_WIDTH-1:0]           idx;
    logic [WORD_W-1:0]              sel_data;
    logic [MVB_ITEMS-1:0]           sel_vld;

    // (base + off) mod MUX_WIDTH. This stays correct for port counts that are
    // not a power of two.
    function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                      input int off);
        int sum;
        sum = (int'(base) + off) % MUX_WIDTH;
        return sum[SEL_WIDTH-1:0];
    endfunction

    // Grant: first ready port at or after ptr, with wrap-around.
    always_comb begin
        free    = !tx_src_rdy_q || TX_DST_RDY;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < MUX_WIDTH; i++) begin
            idx = wrap_add(ptr_q, i);
            // In priority mode, port 0 is excluded from the rotation.
            if (!gnt_vld && RX_SRC_RDY[idx] && (!PRIO_EN || idx != '0)) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (PRIO_EN && RX_SRC_RDY[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = '0;
        end
        // No grant is offered while the output register is stalled or during reset.
        if (!(free && RESET_N)) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        RX_DST_RDY = '0;
        if (gnt_vld) begin
            RX_DST_RDY[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_vld  = '0;
        for (int p = 0; p < MUX_WIDTH; p++) begin
            if (gnt_idx == SEL_WIDTH'(p)) begin
                sel_data = RX_DATA[p*WORD_W +: WORD_W];
                sel_vld  = RX_VLD[p*MVB_ITEMS +: MVB_ITEMS];
            end
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        tx_src_rdy_d = tx_src_rdy_q;
        tx_data_d    = tx_data_q;
        tx_sel_d     = tx_sel_q;
        tx_vld_d     = tx_vld_q;
        if (gnt_vld) begin
            if (!(PRIO_EN && gnt_idx == '0)) begin
                ptr_d = wrap_add(gnt_idx, 1);
            end
            // An empty word consumes the grant but does not load the register.
            if (|sel_vld) begin
                tx_src_rdy_d = 1'b1;
                tx_data_d    = sel_data;
                tx_vld_d     = sel_vld;
                tx_sel_d     = {MVB_ITEMS{gnt_idx}};
            end else begin
                tx_src_rdy_d = 1'b0;
            end
        end else if (free) begin
            tx_src_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q        <= '0;
            tx_src_rdy_q <= 1'b0;
            tx_data_q    <= '0;
            tx_sel_q     <= '0;
            tx_vld_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tx_src_rdy_q <= tx_src_rdy_d;
            tx_data_q    <= tx_data_d;
            tx_sel_q     <= tx_sel_d;
            tx_vld_q     <= tx_vld_d;
        end
    end

    assign TX_DATA    = tx_data_q;
    assign TX_SEL     = tx_sel_q;
    assign TX_VLD     = tx_vld_q;
    assign TX_SRC_RDY = tx_src_rdy_q;

endmodule

// File: tb/tb_mvb_rr_merge.sv
// tb/tb_mvb_rr_merge.sv - directed self-checking bench for mvb_rr_merge

module tb_mvb_rr_merge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] rx_data;
    logic [15:0]  rx_vld;
    logic [3:0]   rx_src_rdy;
    logic [3:0]   rx_dst_rdy;
    logic [127:0] tx_data;
    logic [7:0]   tx_sel;
    logic [3:0]   tx_vld;
    logic         tx_src_rdy;
    logic         tx_dst_rdy;

    int checks   = 0;
    int failures = 0;
    int cnt[4];
    int exp_g;
    int last_g;

    always #5 clk = ~clk;

    mvb_rr_merge #(
        .MVB_ITEMS (4),
        .DATA_WIDTH(32),
        .MUX_WIDTH (4)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .RX_DATA   (rx_data),
        .RX_VLD    (rx_vld),
        .RX_SRC_RDY(rx_src_rdy),
        .RX_DST_RDY(rx_dst_rdy),
        .TX_DATA   (tx_data),
        .TX_SEL    (tx_sel),
        .TX_VLD    (tx_vld),
        .TX_SRC_RDY(tx_src_rdy),
        .TX_DST_RDY(tx_dst_rdy)
    );

    function automatic logic [127:0] mk(input int p, input int n);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*32 +: 32] = 32'hA000_0000 | (32'(p) << 16) | (32'(n) << 8) | 32'(i);
        end
        return w;
    endfunction

    task automatic drive_all();
        for (int p = 0; p < 4; p++) begin
            rx_data[p*128 +: 128] = mk(p, cnt[p]);
        end
    endtask

    // Returns at posedge+1 with reset released and ptr at 0.
    task automatic apply_reset();
        rst_n      = 1'b0;
        rx_src_rdy = '0;
        rx_vld     = '0;
        rx_data    = '0;
        tx_dst_rdy = 1'b1;
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        rx_src_rdy = 4'hF;
        rx_vld     = 16'hFFFF;
        tx_dst_rdy = 1'b1;
        drive_all();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_dst_rdy !== 4'h0) begin failures++; $display("FAIL reset_dst_rdy got=%h exp=0", rx_dst_rdy); end
        checks++; if (tx_src_rdy !== 1'b0) begin failures++; $display("FAIL reset_src_rdy got=%b exp=0", tx_src_rdy); end
        checks++; if (tx_vld !== 4'h0) begin failures++; $display("FAIL reset_vld got=%h exp=0", tx_vld); end
        checks++; if (tx_data !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", tx_data); end
        checks++; if (tx_sel !== 8'h0) begin failures++; $display("FAIL reset_sel got=%h exp=0", tx_sel); end
        rst_n = 1'b1;
        #1;
        checks++; if (rx_dst_rdy !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", rx_dst_rdy); end
        @(posedge clk);
        #1;
        checks++; if (tx_src_rdy !== 1'b1) begin failures++; $display("FAIL first_word_rdy got=%b exp=1", tx_src_rdy); end
        checks++; if (tx_sel !== 8'h00) begin failures++; $display("FAIL first_word_sel got=%h exp=00", tx_sel); end
        checks++; if (tx_data !== mk(0, 0)) begin failures++; $display("FAIL first_word_data got=%h exp=%h", tx_data, mk(0, 0)); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_src_rdy !== 1'b0) begin failures++; $display("FAIL async_reset_rdy got=%b exp=0", tx_src_rdy); end
        checks++; if (tx_vld !== 4'h0) begin failures++; $display("FAIL async_reset_vld got=%h exp=0", tx_vld); end
    endtask

    task automatic test_saturation();
        logic [1:0] g2;
        apply_reset();
        exp_g      = 0;
        rx_src_rdy = 4'hF;
        rx_vld     = 16'hFFFF;
        for (int c = 0; c < 8; c++) begin
            drive_all();
            #1;
            checks++; if (rx_dst_rdy !== 4'(1 << exp_g)) begin failures++; $display("FAIL sat_grant c=%0d got=%b exp=%b", c, rx_dst_rdy, 4'(1 << exp_g)); end
            @(posedge clk);
            #1;
            g2 = exp_g[1:0];
            checks++; if (tx_src_rdy !== 1'b1) begin failures++; $display("FAIL sat_rdy c=%0d got=%b exp=1", c, tx_src_rdy); end
            checks++; if (tx_sel !== {4{g2}}) begin failures++; $display("FAIL sat_sel c=%0d got=%h exp=%h", c, tx_sel, {4{g2}}); end
            checks++; if (tx_data !== mk(exp_g, cnt[exp_g])) begin failures++; $display("FAIL sat_data c=%0d got=%h exp=%h", c, tx_data, mk(exp_g, cnt[exp_g])); end
            cnt[exp_g]++;
            last_g = exp_g;
            exp_g  = (exp_g + 1) % 4;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held_data;
        logic [1:0]   g2;
        held_data  = mk(last_g, cnt[last_g] - 1);
        g2         = last_g[1:0];
        tx_dst_rdy = 1'b0;
        drive_all();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rx_dst_rdy !== 4'h0) begin failures++; $display("FAIL bp_dst_rdy c=%0d got=%b exp=0000", c, rx_dst_rdy); end
            checks++; if (tx_src_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy c=%0d got=%b exp=1", c, tx_src_rdy); end
            checks++; if (tx_data !== held_data) begin failures++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, tx_data, held_data); end
            checks++; if (tx_sel !== {4{g2}}) begin failures++; $display("FAIL bp_sel c=%0d got=%h exp=%h", c, tx_sel, {4{g2}}); end
            @(posedge clk);
            #1;
        end
        tx_dst_rdy = 1'b1;
        #1;
        checks++; if (rx_dst_rdy !== 4'(1 << exp_g)) begin failures++; $display("FAIL bp_release_grant got=%b exp=%b", rx_dst_rdy, 4'(1 << exp_g)); end
        @(posedge clk);
        #1;
        g2 = exp_g[1:0];
        checks++; if (tx_sel !== {4{g2}}) begin failures++; $display("FAIL bp_next_sel got=%h exp=%h", tx_sel, {4{g2}}); end
        checks++; if (tx_data !== mk(exp_g, cnt[exp_g])) begin failures++; $display("FAIL bp_next_data got=%h exp=%h", tx_data, mk(exp_g, cnt[exp_g])); end
        cnt[exp_g]++;
        rx_src_rdy = 4'h0;
    endtask

    task automatic test_sparse();
        logic [127:0] a;
        a = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        apply_reset();
        rx_src_rdy          = 4'b0100;
        rx_vld              = 16'h0500;
        rx_data[256 +: 128] = a;
        #1;
        checks++; if (rx_dst_rdy !== 4'b0100) begin failures++; $display("FAIL sparse_grant got=%b exp=0100", rx_dst_rdy); end
        @(posedge clk);
        #1;
        checks++; if (tx_vld !== 4'b0101) begin failures++; $display("FAIL sparse_vld got=%b exp=0101", tx_vld); end
        checks++; if (tx_data !== a) begin failures++; $display("FAIL sparse_data got=%h exp=%h", tx_data, a); end
        checks++; if (tx_sel !== 8'hAA) begin failures++; $display("FAIL sparse_sel got=%h exp=aa", tx_sel); end
        checks++; if (tx_src_rdy !== 1'b1) begin failures++; $display("FAIL sparse_rdy got=%b exp=1", tx_src_rdy); end
        rx_src_rdy = 4'hF;
        rx_vld     = 16'hFFFF;
        #1;
        checks++; if (rx_dst_rdy !== 4'b1000) begin failures++; $display("FAIL sparse_ptr3 got=%b exp=1000", rx_dst_rdy); end
        @(posedge clk);
        #1;
        checks++; if (tx_sel !== 8'hFF) begin failures++; $display("FAIL sparse_next_sel got=%h exp=ff", tx_sel); end
        rx_src_rdy = 4'h0;
    endtask

    task automatic test_empty_word();
        apply_reset();
        rx_src_rdy = 4'b1010;
        rx_vld     = 16'hF000;
        drive_all();
        #1;
        checks++; if (rx_dst_rdy !== 4'b0010) begin failures++; $display("FAIL empty_grant got=%b exp=0010", rx_dst_rdy); end
        @(posedge clk);
        #1;
        checks++; if (tx_src_rdy !== 1'b0) begin failures++; $display("FAIL empty_no_emit got=%b exp=0", tx_src_rdy); end
        #1;
        checks++; if (rx_dst_rdy !== 4'b1000) begin failures++; $display("FAIL empty_next_grant got=%b exp=1000", rx_dst_rdy); end
        @(posedge clk);
        #1;
        checks++; if (tx_src_rdy !== 1'b1) begin failures++; $display("FAIL empty_p3_rdy got=%b exp=1", tx_src_rdy); end
        checks++; if (tx_sel !== 8'hFF) begin failures++; $display("FAIL empty_p3_sel got=%h exp=ff", tx_sel); end
        rx_src_rdy = 4'b0010;
        #1;
        checks++; if (rx_dst_rdy !== 4'b0010) begin failures++; $display("FAIL empty_drain_grant got=%b exp=0010", rx_dst_rdy); end
        @(posedge clk);
        #1;
        checks++; if (tx_src_rdy !== 1'b0) begin failures++; $display("FAIL empty_drain_rdy got=%b exp=0", tx_src_rdy); end
        rx_src_rdy = 4'h0;
    endtask

    task automatic test_port0_contention();
        logic [3:0] exp;
        apply_reset();
        rx_src_rdy = 4'b0011;
        rx_vld     = 16'hFFFF;
        drive_all();
        for (int c = 0; c < 4; c++) begin
`ifdef MVB_MERGE_PRIO_EN
            exp = 4'b0001;
`else
            exp = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            #1;
            checks++; if (rx_dst_rdy !== exp) begin failures++; $display("FAIL contend_grant c=%0d got=%b exp=%b", c, rx_dst_rdy, exp); end
            @(posedge clk);
            #1;
        end
        rx_src_rdy = 4'b0010;
        #1;
        checks++; if (rx_dst_rdy !== 4'b0010) begin failures++; $display("FAIL contend_port1 got=%b exp=0010", rx_dst_rdy); end
        rx_src_rdy = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_saturation();
        test_backpressure();
        test_sparse();
        test_empty_word();
        test_port0_contention();
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mvb_rr_merge.md
# mvb_rr_merge

Merges `MUX_WIDTH` independent MVB streams into one MVB stream by round-robin arbitration at whole-word granularity. Every output item carries the index of the input port it came from. This makes it the counterpart of the per-item-select MVB demultiplexer: a word merged here and fed to the demux with the same port count is routed back to its source index. It sits in front of shared pipelines (DMA, hash, lookup) that serve several MVB producers.

## Interface
- `MVB_ITEMS`, 4: items per MVB word (≥1).
- `DATA_WIDTH`, 32: bits per item (≥1).
- `MUX_WIDTH`, 4: number of RX ports (≥2). Define `SEL_WIDTH = $clog2(MUX_WIDTH)`.
- `CLK`  in  1  clock; all logic is rising-edge.
- `RESET_N`  in  1  reset, asynchronous, active-low.
- `RX_DATA`  in  MUX_WIDTH*MVB_ITEMS*DATA_WIDTH  input words; port p occupies slice p.
- `RX_VLD`  in  MUX_WIDTH*MVB_ITEMS  per-item valid; port p occupies slice p.
- `RX_SRC_RDY`  in  MUX_WIDTH  per-port word present.
- `RX_DST_RDY`  out  MUX_WIDTH  per-port accept; one-hot or zero.
- `TX_DATA`  out  MVB_ITEMS*DATA_WIDTH  merged word.
- `TX_SEL`  out  MVB_ITEMS*SEL_WIDTH  source port index per item.
- `TX_VLD`  out  MVB_ITEMS  per-item valid.
- `TX_SRC_RDY`  out  1  output word present.
- `TX_DST_RDY`  in  1  downstream accept.

## Operation
- RX transfer on port p: `RX_SRC_RDY[p] & RX_DST_RDY[p]`. TX transfer: `TX_SRC_RDY & TX_DST_RDY`.
- Output stage: a single register with `free = !TX_SRC_RDY | TX_DST_RDY`.
- Grant, combinational:
  - If `free` and `RESET_N`=1, grant g is the first port with `RX_SRC_RDY` set, searching from round-robin pointer `ptr` upward with wrap.
  - `RX_DST_RDY` is one-hot at g, else all zero.
- On an RX transfer from g:
  - Load TX_DATA, TX_VLD ← port g's slices.
  - Load every TX_SEL item ← g.
  - `ptr` ← (g+1) mod MUX_WIDTH.
- Empty words (SRC_RDY=1, all VLD=0) are accepted and consume the grant. The pointer advances, but the register is not loaded; TX_SRC_RDY ← 0 if the register was being drained that cycle.
- No RX transfer while `free`: TX_SRC_RDY ← 0. `ptr` unchanged.
- Not `free`: register holds all fields; `RX_DST_RDY` = 0; `ptr` unchanged.
- Items with VLD=0 keep their DATA/SEL bits; downstream treats them as don't-care.
- Word integrity: item order and positions inside a word are preserved. Items from different ports are never mixed in one word.
- Reset, asynchronous while RESET_N=0:
  - `ptr`=0, TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, TX_SEL=0.
  - RX_DST_RDY=0 for the whole reset.
- Reset mid-transfer discards the held word. No RX handshake occurs in the cycle RESET_N is low at the clock edge.

## Timing
- Latency: RX transfer at edge k → word on TX from edge k (visible in cycle k+1).
- Throughput: 1 word/cycle with TX_DST_RDY held high; any number of ports active.
- Combinational paths:
  - RX_DST_RDY depends on TX_DST_RDY, TX_SRC_RDY, RX_SRC_RDY, `ptr`, RESET_N.
  - No combinational path RX_DATA/RX_VLD → TX.
- TX stability: while TX_SRC_RDY=1 and TX_DST_RDY=0, all TX outputs are held constant.
- Fairness: with all ports continuously ready and TX_DST_RDY=1, grants cycle 0,1,…,MUX_WIDTH-1,0,… Each port waits at most MUX_WIDTH-1 grants.

## Configuration
- `MVB_MERGE_PRIO_EN`
  - Defined: port 0 has strict priority. If `RX_SRC_RDY[0]` and `free`, g=0 regardless of `ptr`, and `ptr` is not updated by port-0 grants. Ports 1..MUX_WIDTH-1 round-robin among themselves using `ptr` as above.
  - Undefined: pure round-robin over all ports as described.
- Reset values, latency and handshake rules are identical in both builds.

## Test plan
- Reset: RESET_N=0 with all RX_SRC_RDY=1 → RX_DST_RDY=0, TX_SRC_RDY=0. After release, the first grant goes to port 0.
- Saturation, MUX_WIDTH=4, all ports ready, TX_DST_RDY=1 → TX_SEL sequence 0,1,2,3,0,… and one word per cycle. Data matches the per-port scoreboard in order.
- Backpressure: TX_DST_RDY=0 for 5 cycles with TX_SRC_RDY=1 → TX outputs constant, RX_DST_RDY=0. The word is released on the first cycle TX_DST_RDY=1 and the next grant is taken in that same cycle.
- Sparse traffic: only port 2 ready with word VLD=0b0101, data A → next cycle TX_VLD=0b0101, TX_DATA=A, every TX_SEL item=2, `ptr`=3.
- Empty word: port 1 sends VLD=0 while ports 1 and 3 are ready → port 1 is acknowledged, nothing is emitted, and port 3 is granted the next cycle.
- `MVB_MERGE_PRIO_EN`: ports 0 and 1 continuously ready → only port 0 is ever granted. Once port 0 drops, port 1 is granted within 1 cycle.
